// File: rtl/mult_share_arb_pkg.sv
// Shared types and the round-robin pick used by the multiplier-sharing arbiter.
// req_id_t is sized from NUM_REQ_DEF; the arbiter's NUM_REQ must not exceed 2**ID_W.
package mult_share_pkg;

    localparam int NUM_REQ_DEF = 4;
    localparam int ID_W        = $clog2(NUM_REQ_DEF);
    localparam int RR_MAX      = 32;
    localparam int RR_IDX_W    = 5;

    typedef logic [ID_W-1:0] req_id_t;

    typedef struct packed {
        logic                found;
        logic [RR_IDX_W-1:0] id;
    } rr_pick_t;

    // First set bit of val at or after ptr+1, wrapping at n. ptr must be below n.
    function automatic rr_pick_t rr_pick(input logic [RR_MAX-1:0]   val,
                                         input logic [RR_IDX_W-1:0] ptr,
                                         input int                  n);
        rr_pick_t r;
        int       idx;
        r = '0;
        for (int i = 0; i < RR_MAX; i++) begin
            idx = int'(ptr) + 1 + i;
            if (idx >= n) idx = idx - n;
            if (i < n && !r.found && val[idx[RR_IDX_W-1:0]]) begin
                r.found = 1'b1;
                r.id    = idx[RR_IDX_W-1:0];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/mult_share_arb_if.sv
// Requester-side and multiplier-side handshake bundle of the sharing arbiter.
// Every val/rdy pair transfers on a rising clock edge where both are high; the
// sender holds val and data stable until that edge.
interface mult_share_arb_if #(
    parameter int BITS    = 1024,
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]      i_req_val;
    logic [NUM_REQ-1:0]      o_req_rdy;
    logic [NUM_REQ*BITS-1:0] i_req_dat_a;
    logic [NUM_REQ*BITS-1:0] i_req_dat_b;
    logic [NUM_REQ-1:0]      o_rsp_val;
    logic [NUM_REQ-1:0]      i_rsp_rdy;
    logic [2*BITS-1:0]       o_rsp_dat;
    logic                    o_mul_val;
    logic                    i_mul_rdy;
    logic [BITS-1:0]         o_mul_dat_a;
    logic [BITS-1:0]         o_mul_dat_b;
    logic                    i_mul_val;
    logic                    o_mul_rdy;
    logic [2*BITS-1:0]       i_mul_dat;

    modport slave (
        input  i_req_val, i_req_dat_a, i_req_dat_b, i_rsp_rdy,
        input  i_mul_rdy, i_mul_val, i_mul_dat,
        output o_req_rdy, o_rsp_val, o_rsp_dat,
        output o_mul_val, o_mul_dat_a, o_mul_dat_b, o_mul_rdy
    );

    modport master (
        output i_req_val, i_req_dat_a, i_req_dat_b, i_rsp_rdy,
        output i_mul_rdy, i_mul_val, i_mul_dat,
        input  o_req_rdy, o_rsp_val, o_rsp_dat,
        input  o_mul_val, o_mul_dat_a, o_mul_dat_b, o_mul_rdy
    );

endinterface

// File: rtl/mult_share_arb_tag_fifo.sv
// In-order FIFO of requester IDs for operations handed to the multiplier.
module mult_tag_fifo
    import mult_share_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             push,
    input  req_id_t          push_id,
    input  logic             pop,
    output req_id_t          head,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    req_id_t          mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];
    assign do_push = push && (count != CNT_W'(DEPTH));
    assign do_pop  = pop && !empty;

    always_ff @(posedge i_clk) begin
        if (do_push) mem[wr_ptr] <= push_id;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mult_share_arb.sv
// Round-robin sharing of one pipelined multiplier among NUM_REQ requesters;
// results return in issue order to the requester recorded at the tag FIFO head.
module mult_share_arb
    import mult_share_pkg::*;
#(
    parameter int BITS         = 1024,
    parameter int NUM_REQ      = 4,
    parameter int MAX_INFLIGHT = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    mult_share_arb_if.slave  bus,
    output logic             o_err
);

    localparam int CNT_W = $clog2(MAX_INFLIGHT + 1);
    localparam int CR_W  = CNT_W + 1;

    logic             mul_val_q;
    logic [BITS-1:0]  a_q;
    logic [BITS-1:0]  b_q;
    req_id_t          issue_id_q;
    req_id_t          rr_ptr_q;
    logic             err_q;

    logic [CNT_W-1:0] fifo_count;
    logic             fifo_empty;
    req_id_t          head_id;
    logic [CR_W-1:0]  credits;
    rr_pick_t         pick;
    req_id_t          grant_id;
    logic             load;
    logic             push;
    logic             pop;
    logic             mul_rdy;

    // Credits count the issue register plus queued tags; pops free a credit only next cycle.
    assign credits  = CR_W'(fifo_count) + CR_W'(mul_val_q);
    assign pick     = rr_pick(RR_MAX'(bus.i_req_val), RR_IDX_W'(rr_ptr_q), NUM_REQ);
    assign grant_id = req_id_t'(pick.id);
    assign load     = (!mul_val_q || bus.i_mul_rdy) && (credits < CR_W'(MAX_INFLIGHT)) && pick.found;
    assign push     = mul_val_q && bus.i_mul_rdy;
    assign pop      = bus.i_mul_val && mul_rdy && !fifo_empty;

    always_comb begin
        bus.o_req_rdy = '0;
        if (load) bus.o_req_rdy[grant_id] = 1'b1;
    end

    // With no tag outstanding the multiplier is always drained; such a beat is an error.
    always_comb begin
        bus.o_rsp_val = '0;
        mul_rdy       = 1'b1;
        if (!fifo_empty) begin
            bus.o_rsp_val[head_id] = bus.i_mul_val;
            mul_rdy                = bus.i_rsp_rdy[head_id];
        end
    end

    assign bus.o_mul_rdy   = mul_rdy;
    assign bus.o_rsp_dat   = bus.i_mul_dat;
    assign bus.o_mul_val   = mul_val_q;
    assign bus.o_mul_dat_a = a_q;
    assign bus.o_mul_dat_b = b_q;
    assign o_err           = err_q;

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            mul_val_q  <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            issue_id_q <= '0;
            rr_ptr_q   <= req_id_t'(NUM_REQ - 1);
            err_q      <= 1'b0;
        end else begin
            if (load) begin
                mul_val_q  <= 1'b1;
                a_q        <= bus.i_req_dat_a[int'(grant_id)*BITS +: BITS];
                b_q        <= bus.i_req_dat_b[int'(grant_id)*BITS +: BITS];
                issue_id_q <= grant_id;
                rr_ptr_q   <= grant_id;
            end else if (bus.i_mul_rdy) begin
                mul_val_q <= 1'b0;
            end
            if (bus.i_mul_val && fifo_empty) err_q <= 1'b1;
        end
    end

    mult_tag_fifo #(
        .DEPTH (MAX_INFLIGHT)
    ) u_tag_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .push    (push),
        .push_id (issue_id_q),
        .pop     (pop),
        .head    (head_id),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

endmodule

// File: tb/tb_mult_share_arb.sv
// Directed bench for mult_share_arb with a queue-based multiplier model.
module tb_mult_share_arb;

    localparam int BITS = 16;
    localparam int NR   = 4;
    localparam int MI   = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic err;

    always #5 clk = ~clk;

    mult_share_arb_if #(.BITS(BITS), .NUM_REQ(NR)) bus ();

    mult_share_arb #(
        .BITS         (BITS),
        .NUM_REQ      (NR),
        .MAX_INFLIGHT (MI)
    ) dut (
        .i_clk (clk),
        .i_rst (rst_n),
        .bus   (bus),
        .o_err (err)
    );

    int errors = 0;
    int checks = 0;

    logic [BITS-1:0]   req_a [NR];
    logic [BITS-1:0]   req_b [NR];
    int                req_left [NR];
    logic              res_en;
    logic              inj_val;
    logic [2*BITS-1:0] inj_dat;

    logic [2*BITS-1:0] mul_q[$];
    logic [2*BITS-1:0] exp_q[$];
    int                gnt_q[$];
    int                got_id_q[$];
    logic [2*BITS-1:0] got_dat_q[$];
    int                bad_oh;

    logic [NR-1:0]     s_req_rdy;
    logic [NR-1:0]     s_rsp_val;
    logic [2*BITS-1:0] s_rsp_dat;
    logic              s_mul_val;
    logic              s_mul_rdy;
    logic              s_err;
    logic [BITS-1:0]   s_mul_a;
    logic [BITS-1:0]   s_mul_b;

    // Multiplier model: accepts when o_mul_val && i_mul_rdy, presents results in order.
    always @(posedge clk) begin
        if (!rst_n) begin
            mul_q.delete();
        end else begin
            if (bus.i_mul_val && bus.o_mul_rdy && !inj_val && mul_q.size() > 0)
                void'(mul_q.pop_front());
            if (bus.o_mul_val && bus.i_mul_rdy)
                mul_q.push_back({16'b0, bus.o_mul_dat_a} * {16'b0, bus.o_mul_dat_b});
        end
        #2;
        bus.i_mul_val = inj_val || (res_en && mul_q.size() > 0);
        bus.i_mul_dat = inj_val ? inj_dat : ((mul_q.size() > 0) ? mul_q[0] : '0);
    end

    function automatic int oh_idx(input logic [NR-1:0] v);
        int r;
        r = -1;
        for (int i = 0; i < NR; i++) if (v[i] && r < 0) r = i;
        return r;
    endfunction

    task automatic apply_reqs();
        logic [NR-1:0] v;
        for (int k = 0; k < NR; k++) begin
            v[k] = (req_left[k] > 0);
            bus.i_req_dat_a[k*BITS +: BITS] = req_a[k];
            bus.i_req_dat_b[k*BITS +: BITS] = req_b[k];
        end
        bus.i_req_val = v;
    endtask

    // Sample at the falling edge, then advance to just after the rising edge.
    task automatic tick();
        @(negedge clk);
        s_req_rdy = bus.o_req_rdy;
        s_rsp_val = bus.o_rsp_val;
        s_rsp_dat = bus.o_rsp_dat;
        s_mul_val = bus.o_mul_val;
        s_mul_rdy = bus.o_mul_rdy;
        s_mul_a   = bus.o_mul_dat_a;
        s_mul_b   = bus.o_mul_dat_b;
        s_err     = err;
        if (s_req_rdy != '0) begin
            gnt_q.push_back(oh_idx(s_req_rdy));
            if (!$onehot(s_req_rdy)) bad_oh++;
        end
        if (s_rsp_val != '0 && !$onehot(s_rsp_val)) bad_oh++;
        if ((s_rsp_val & bus.i_rsp_rdy) != '0) begin
            got_id_q.push_back(oh_idx(s_rsp_val));
            got_dat_q.push_back(s_rsp_dat);
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < NR; k++)
            if (s_req_rdy[k] && req_left[k] > 0) req_left[k]--;
        apply_reqs();
    endtask

    task automatic do_reset();
        rst_n         = 1'b0;
        res_en        = 1'b1;
        inj_val       = 1'b0;
        inj_dat       = '0;
        bus.i_mul_rdy = 1'b1;
        bus.i_rsp_rdy = '1;
        for (int k = 0; k < NR; k++) begin
            req_left[k] = 0;
            req_a[k]    = '0;
            req_b[k]    = '0;
        end
        apply_reqs();
        tick();
        tick();
        gnt_q.delete();
        got_id_q.delete();
        got_dat_q.delete();
        exp_q.delete();
        bad_oh = 0;
        rst_n  = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        tick();
        checks++; if (s_mul_val !== 1'b0) begin errors++; $display("FAIL reset_mul_val got=%0b exp=0", s_mul_val); end
        checks++; if (s_req_rdy !== 4'b0000) begin errors++; $display("FAIL reset_req_rdy got=%b exp=0000", s_req_rdy); end
        checks++; if (s_rsp_val !== 4'b0000) begin errors++; $display("FAIL reset_rsp_val got=%b exp=0000", s_rsp_val); end
        checks++; if (s_err !== 1'b0) begin errors++; $display("FAIL reset_err got=%0b exp=0", s_err); end
        checks++; if (s_mul_rdy !== 1'b1) begin errors++; $display("FAIL reset_mul_rdy got=%0b exp=1", s_mul_rdy); end
    endtask

    task automatic test_single();
        do_reset();
        req_a[0] = 16'd3; req_b[0] = 16'd5; req_left[0] = 1;
        apply_reqs();
        tick();
        checks++; if (s_req_rdy !== 4'b0001) begin errors++; $display("FAIL single_req_rdy got=%b exp=0001", s_req_rdy); end
        tick();
        checks++; if (s_mul_val !== 1'b1) begin errors++; $display("FAIL single_mul_val got=%0b exp=1", s_mul_val); end
        checks++; if (s_mul_a !== 16'd3 || s_mul_b !== 16'd5) begin errors++; $display("FAIL single_operands got=%0d,%0d exp=3,5", s_mul_a, s_mul_b); end
        checks++; if (s_rsp_val !== 4'b0000) begin errors++; $display("FAIL single_early_rsp got=%b exp=0000", s_rsp_val); end
        tick();
        checks++; if (s_rsp_val !== 4'b0001) begin errors++; $display("FAIL single_rsp_val got=%b exp=0001", s_rsp_val); end
        checks++; if (s_rsp_dat !== 32'd15) begin errors++; $display("FAIL single_rsp_dat got=%0d exp=15", s_rsp_dat); end
        tick();
        checks++; if (s_rsp_val !== 4'b0000) begin errors++; $display("FAIL single_rsp_after got=%b exp=0000", s_rsp_val); end
        checks++; if (got_id_q.size() !== 1) begin errors++; $display("FAIL single_count got=%0d exp=1", got_id_q.size()); end
    endtask

    task automatic test_round_robin();
        int exp_gnt [5];
        int exp_id  [5];
        exp_gnt = '{0, 1, 2, 3, 0};
        exp_id  = '{0, 1, 2, 3, 0};
        do_reset();
        for (int k = 0; k < NR; k++) begin
            req_a[k]    = 16'(k + 1);
            req_b[k]    = 16'd10;
            req_left[k] = (k == 0) ? 2 : 1;
        end
        exp_q = '{32'd10, 32'd20, 32'd30, 32'd40, 32'd10};
        apply_reqs();
        for (int i = 0; i < 60 && got_dat_q.size() < 5; i++) tick();
        checks++; if (gnt_q.size() !== 5) begin errors++; $display("FAIL rr_grant_count got=%0d exp=5", gnt_q.size()); end
        checks++; if (got_dat_q.size() !== 5) begin errors++; $display("FAIL rr_result_count got=%0d exp=5", got_dat_q.size()); end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (i >= gnt_q.size() || gnt_q[i] !== exp_gnt[i]) begin
                errors++; $display("FAIL rr_grant[%0d] got=%0d exp=%0d", i, (i < gnt_q.size()) ? gnt_q[i] : -1, exp_gnt[i]);
            end
            checks++;
            if (i >= got_dat_q.size() || got_id_q[i] !== exp_id[i] || got_dat_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL rr_result[%0d] got=id%0d/%0d exp=id%0d/%0d", i,
                    (i < got_id_q.size()) ? got_id_q[i] : -1, (i < got_dat_q.size()) ? got_dat_q[i] : 0, exp_id[i], exp_q[i]);
            end
        end
        checks++; if (bad_oh !== 0) begin errors++; $display("FAIL rr_onehot got=%0d exp=0", bad_oh); end
    endtask

    task automatic test_head_stall();
        int stall_bad;
        do_reset();
        bus.i_rsp_rdy = 4'b1011;
        req_a[2] = 16'd7; req_b[2] = 16'd6; req_left[2] = 1;
        req_a[3] = 16'd9; req_b[3] = 16'd9; req_left[3] = 1;
        apply_reqs();
        for (int i = 0; i < 20 && !s_rsp_val[2]; i++) tick();
        checks++; if (s_rsp_val !== 4'b0100 || s_rsp_dat !== 32'd42) begin errors++; $display("FAIL stall_head got=%b/%0d exp=0100/42", s_rsp_val, s_rsp_dat); end
        stall_bad = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (s_mul_rdy !== 1'b0 || s_rsp_val !== 4'b0100 || s_rsp_dat !== 32'd42) stall_bad++;
        end
        checks++; if (stall_bad !== 0) begin errors++; $display("FAIL stall_hold got=%0d bad cycles exp=0", stall_bad); end
        checks++; if (got_id_q.size() !== 0) begin errors++; $display("FAIL stall_early got=%0d deliveries exp=0", got_id_q.size()); end
        bus.i_rsp_rdy = '1;
        for (int i = 0; i < 10 && got_id_q.size() < 2; i++) tick();
        checks++; if (got_id_q.size() !== 2) begin errors++; $display("FAIL stall_release_count got=%0d exp=2", got_id_q.size()); end
        checks++;
        if (got_id_q.size() < 2 || got_id_q[0] !== 2 || got_dat_q[0] !== 32'd42 || got_id_q[1] !== 3 || got_dat_q[1] !== 32'd81) begin
            errors++; $display("FAIL stall_release_order got=%0d deliveries exp=id2/42 then id3/81", got_id_q.size());
        end
    endtask

    task automatic test_credit_limit();
        do_reset();
        res_en = 1'b0;
        for (int k = 0; k < NR; k++) begin
            req_a[k] = 16'(k + 1); req_b[k] = 16'd1; req_left[k] = 3;
        end
        apply_reqs();
        repeat (12) tick();
        checks++; if (gnt_q.size() !== MI) begin errors++; $display("FAIL credit_accepts got=%0d exp=%0d", gnt_q.size(), MI); end
        checks++; if (s_req_rdy !== 4'b0000) begin errors++; $display("FAIL credit_req_rdy got=%b exp=0000", s_req_rdy); end
        checks++; if (s_mul_val !== 1'b0) begin errors++; $display("FAIL credit_mul_val got=%0b exp=0", s_mul_val); end
        res_en = 1'b1;
        for (int i = 0; i < 10 && gnt_q.size() < MI + 1; i++) tick();
        checks++; if (gnt_q.size() !== MI + 1) begin errors++; $display("FAIL credit_resume got=%0d exp=%0d", gnt_q.size(), MI + 1); end
        checks++; if (gnt_q.size() < MI + 1 || gnt_q[MI] !== 0) begin errors++; $display("FAIL credit_resume_id got=%0d exp=0", (gnt_q.size() > MI) ? gnt_q[MI] : -1); end
        checks++; if (got_id_q.size() < 1 || got_dat_q[0] !== 32'd1) begin errors++; $display("FAIL credit_first_result got=%0d deliveries exp first=1", got_id_q.size()); end
    endtask

    task automatic test_orphan_result();
        do_reset();
        res_en  = 1'b0;
        inj_dat = 32'hDEAD;
        inj_val = 1'b1;
        tick();
        checks++; if (s_mul_rdy !== 1'b1) begin errors++; $display("FAIL orphan_mul_rdy got=%0b exp=1", s_mul_rdy); end
        checks++; if (s_rsp_val !== 4'b0000) begin errors++; $display("FAIL orphan_rsp_val got=%b exp=0000", s_rsp_val); end
        inj_val = 1'b0;
        tick();
        checks++; if (s_err !== 1'b1) begin errors++; $display("FAIL orphan_err got=%0b exp=1", s_err); end
        repeat (5) tick();
        checks++; if (s_err !== 1'b1) begin errors++; $display("FAIL orphan_err_sticky got=%0b exp=1", s_err); end
        checks++; if (got_id_q.size() !== 0) begin errors++; $display("FAIL orphan_delivered got=%0d exp=0", got_id_q.size()); end
    endtask

    task automatic test_reset_inflight();
        res_en = 1'b0;
        bus.i_mul_rdy = 1'b1;
        req_a[1] = 16'd2; req_b[1] = 16'd2; req_left[1] = 1;
        req_a[2] = 16'd3; req_b[2] = 16'd3; req_left[2] = 1;
        apply_reqs();
        for (int i = 0; i < 10 && gnt_q.size() < 2; i++) tick();
        bus.i_mul_rdy = 1'b0;
        tick();
        checks++; if (s_mul_val !== 1'b1) begin errors++; $display("FAIL inflight_mul_val got=%0b exp=1", s_mul_val); end
        checks++; if (s_err !== 1'b1) begin errors++; $display("FAIL inflight_err_before got=%0b exp=1", s_err); end
        rst_n = 1'b0;
        tick();
        res_en = 1'b1;
        tick();
        checks++; if (s_mul_val !== 1'b0) begin errors++; $display("FAIL rst_mul_val got=%0b exp=0", s_mul_val); end
        checks++; if (s_rsp_val !== 4'b0000) begin errors++; $display("FAIL rst_rsp_val got=%b exp=0000", s_rsp_val); end
        checks++; if (s_err !== 1'b0) begin errors++; $display("FAIL rst_err got=%0b exp=0", s_err); end
        checks++; if (s_mul_rdy !== 1'b1) begin errors++; $display("FAIL rst_mul_rdy got=%0b exp=1", s_mul_rdy); end
        gnt_q.delete();
        got_id_q.delete();
        got_dat_q.delete();
        rst_n = 1'b1;
        bus.i_mul_rdy = 1'b1;
        for (int k = 0; k < NR; k++) begin
            req_a[k] = 16'(k + 1); req_b[k] = 16'(k + 1); req_left[k] = 1;
        end
        exp_q = '{32'd1, 32'd4, 32'd9, 32'd16};
        apply_reqs();
        for (int i = 0; i < 40 && got_dat_q.size() < 4; i++) tick();
        repeat (4) tick();
        checks++; if (gnt_q.size() < 1 || gnt_q[0] !== 0) begin errors++; $display("FAIL rst_first_grant got=%0d exp=0", (gnt_q.size() > 0) ? gnt_q[0] : -1); end
        checks++; if (got_dat_q.size() !== 4) begin errors++; $display("FAIL rst_result_count got=%0d exp=4", got_dat_q.size()); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (i >= got_dat_q.size() || got_id_q[i] !== i || got_dat_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL rst_result[%0d] got=%0d exp=id%0d/%0d", i, (i < got_dat_q.size()) ? got_dat_q[i] : 0, i, exp_q[i]);
            end
        end
    endtask

    initial begin
        bus.i_req_val   = '0;
        bus.i_req_dat_a = '0;
        bus.i_req_dat_b = '0;
        bus.i_rsp_rdy   = '1;
        bus.i_mul_rdy   = 1'b1;
        bus.i_mul_val   = 1'b0;
        bus.i_mul_dat   = '0;
        res_en          = 1'b1;
        inj_val         = 1'b0;
        inj_dat         = '0;
        bad_oh          = 0;
        for (int k = 0; k < NR; k++) begin
            req_left[k] = 0; req_a[k] = '0; req_b[k] = '0;
        end
        test_reset();
        test_single();
        test_round_robin();
        test_head_stall();
        test_credit_limit();
        test_orphan_result();
        test_reset_inflight();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired before summary");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mult_share_arb.md
Name: mult_share_arb

Overview:
Shares one accum_mult_ram_mod instance among NUM_REQ requesters.
- Grants requesters round-robin and registers the granted operand pair toward the multiplier.
- Records each issued requester ID in an in-order tag FIFO.
- Routes each multiplier result back to the requester at the FIFO head.
- Sits between the squaring/exponentiation control units and the shared multiplier.

Parameters:
BITS, 1024, operand width; result is 2*BITS.
NUM_REQ, 4, number of requesters (>=2).
MAX_INFLIGHT, 4, maximum outstanding operations (issue register plus tag FIFO).
ID_W, $clog2(NUM_REQ), requester ID width (derived, not overridden).

Ports:
i_clk  in  1  clock.
i_rst  in  1  synchronous, active-low reset.
i_req_val  in  NUM_REQ  per-requester operand valid.
o_req_rdy  out  NUM_REQ  per-requester accept, one-hot or zero.
i_req_dat_a  in  NUM_REQ*BITS  operand A; requester k occupies slice [k*BITS +: BITS].
i_req_dat_b  in  NUM_REQ*BITS  operand B; same slicing.
o_rsp_val  out  NUM_REQ  per-requester result valid, one-hot or zero.
i_rsp_rdy  in  NUM_REQ  per-requester result ready.
o_rsp_dat  out  2*BITS  result bus shared by all requesters.
o_mul_val  out  1  to multiplier i_val.
i_mul_rdy  in  1  from multiplier o_rdy.
o_mul_dat_a  out  BITS  to multiplier i_dat_a.
o_mul_dat_b  out  BITS  to multiplier i_dat_b.
i_mul_val  in  1  from multiplier o_val.
o_mul_rdy  out  1  to multiplier i_rdy.
i_mul_dat  in  2*BITS  from multiplier o_dat.
o_err  out  1  sticky protocol error flag.

Behaviour:
- Reset (i_rst==0 at posedge):
  - o_mul_val=0, tag FIFO empty, credit count=0, o_err=0.
  - RR pointer=NUM_REQ-1, so requester 0 has first priority.
  - Combinational outputs follow: o_req_rdy=0, o_rsp_val=0.
  - The multiplier must share this reset; in-flight work is discarded with no responses.
- Credits = issue-register occupancy + FIFO entries. Range 0..MAX_INFLIGHT.
- Issue load condition: (!o_mul_val || i_mul_rdy) && credits<MAX_INFLIGHT && |i_req_val.
  - Credits freed by a same-cycle pop become usable the following cycle (no bypass).
- Grant: first k with i_req_val[k], searching from pointer+1 upward with wrap.
  - o_req_rdy[k]=1 combinationally in the load cycle only.
  - On load: operands captured and pointer set to k.
- Latency: request accepted at edge T -> o_mul_val=1 from T+1.
  - o_mul_val and o_mul_dat_* hold stable until i_mul_rdy.
- Multiplier accept (o_mul_val && i_mul_rdy): push the granted ID into the FIFO.
  - FIFO depth MAX_INFLIGHT, so it never overflows.
  - Issue and push in the same cycle are legal.
- Return path, FIFO non-empty, head ID h:
  - o_rsp_val[h]=i_mul_val.
  - o_rsp_dat=i_mul_dat, combinational passthrough.
  - o_mul_rdy=i_rsp_rdy[h].
  - Pop on i_mul_val && o_mul_rdy.
- Results are in order: a stalled head blocks all later results.
- Return path, FIFO empty:
  - o_mul_rdy=1 and o_rsp_val=0.
  - i_mul_val drops the beat and sets o_err=1; o_err is cleared only by reset.
- Push and pop in the same cycle leave the FIFO count unchanged; credit arithmetic is exact at both 0 and MAX_INFLIGHT.
- Requesters must hold val and data until rdy (AXI-stream rule). o_req_rdy may depend on i_req_val.

Decomposition:
- Package mult_share_pkg:
  - req_id_t typedef (ID_W bits).
  - Function rr_pick(val vector, pointer) returning the granted ID and a found flag.
- Sub-module mult_tag_fifo: synchronous FIFO of req_id_t, depth MAX_INFLIGHT.
  - Ports: push, pop, head, empty, count.
  - Same active-low synchronous reset.

Test Plan:
1. Requester 0 only, a=3, b=5 → o_req_rdy[0] in the accept cycle; o_mul_val one cycle later; o_rsp_val[0] with o_rsp_dat=15; all other o_rsp_val low.
2. Requesters 0-3 all held valid, each with a=k+1, b=10 → grant order 0,1,2,3,0; results 10,20,30,40 routed to requesters 0-3 in that order.
3. Head ID=2 with i_rsp_rdy[2]=0 for 20 cycles, later results pending → o_mul_rdy=0 throughout; no later result delivered early; release → delivered in order.
4. Multiplier never asserts o_val, MAX_INFLIGHT=4, i_mul_rdy=1, all requesters valid → exactly 4 accepts, then o_req_rdy=0 until one result pops.
5. i_mul_val pulse with empty FIFO, 0xDEAD → o_mul_rdy=1, o_rsp_val=0, o_err=1 and held until reset.
6. Reset asserted with 2 operations in flight → next cycle o_mul_val=0, o_rsp_val=0, o_err=0; first grant after release goes to requester 0.
